fb_bank_sched: RTL and testbench

Per-bank scheduler in front of one 32768 x 9-bit frame-buffer bank (`mem_bank`). It shares the bank's single `write_req_pkt` port between NUM_REQ pixel/load requesters with round-robin arbitration. It also runs a full-bank clear sweep with forced writes. It enforces the bank's read-after-write gap: loads never see a stale word from an in-flight RMW.

---
 rtl/fb_bank_sched.sv | 225 ++++++++++++++++++++++
 tb/tb_fb_bank_sched.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_bank_sched.sv
// -----------------------------------------------------------------------------
// fb_bank_sched : per-bank scheduler for one 32768 x 9-bit frame-buffer bank.
//
// Shares the bank's single write_req_pkt port between NUM_REQ pixel/load
// requesters with round-robin arbitration. It also runs a full-bank clear
// sweep with forced writes, and it holds back loads whose word is still in
// the bank's two-stage write pipeline.
//
// Ports
//   clk, rst     rising-edge clock, synchronous active-high reset
//   req_valid    per-requester request valid
//   req_ready    one-hot grant (combinational from req_valid/state/hazards)
//   req_we       1 = write, 0 = read
//   req_force    forcewrite flag for writes (ignored for reads)
//   req_addr     NUM_REQ x 18-bit flattened addresses, word index = [17:3]
//   req_data     NUM_REQ x 9-bit flattened write data
//   clear_start  one-cycle pulse that requests a full-bank clear
//   clear_value  fill value, sampled together with clear_start
//   clear_busy   high while the clear sweep and its drain are running
//   clear_done   one-cycle pulse when the clear completes
//   bank_req     registered request to mem_bank (addr/data/en/forcewrite)
//   bank_rdata   mem_bank read data
//   rsp_valid    read response valid (two cycles after the read handshake)
//   rsp_id       requester index of the response
//   rsp_data     read response data (bank_rdata passed through)
// -----------------------------------------------------------------------------
package fb_bank_pkg;
  typedef struct packed {
    logic [17:0] addr;
    logic [8:0]  data;
    logic        en;
    logic        forcewrite;
  } write_req_pkt;
endpackage

module fb_bank_sched
  import fb_bank_pkg::*;
#(
  parameter int         NUM_REQ = 4,
  parameter logic [2:0] BANK_ID = 3'd0,
  localparam int        IW      = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [NUM_REQ-1:0]    req_force,
  input  logic [NUM_REQ*18-1:0] req_addr,
  input  logic [NUM_REQ*9-1:0]  req_data,
  input  logic                  clear_start,
  input  logic [8:0]            clear_value,
  output logic                  clear_busy,
  output logic                  clear_done,
  output write_req_pkt          bank_req,
  input  logic [8:0]            bank_rdata,
  output logic                  rsp_valid,
  output logic [IW-1:0]         rsp_id,
  output logic [8:0]            rsp_data
);

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    CLEAR = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [14:0]       sweep_cnt;
  logic              drain_cnt;     // 0 = first drain cycle, 1 = second
  logic [8:0]        clr_val;
  logic [IW-1:0]     last_grant;

  // Write handshakes of the two preceding cycles: index 0 = T-1, 1 = T-2.
  logic [1:0]        hz_v;
  logic [1:0][14:0]  hz_w;

  // Read issued to the bank last cycle; becomes the response next cycle.
  logic              rd_v;
  logic [IW-1:0]     rd_id;

  logic [NUM_REQ-1:0] cand;
  logic               grant_found;
  logic [IW-1:0]      grant_idx;
  logic               start_clear;
  logic               hs;
  logic [14:0]        sel_word;
  logic [8:0]         sel_data;
  logic               sel_we;
  logic               sel_force;
  logic               unused_addr_bits;

  // ---------------------------------------------------------------------------
  // Candidate filter and round-robin pick.
  // NOTE: every variable written in an always_comb gets a default before any
  // branch; a path that leaves one unassigned would infer a latch.
  // ---------------------------------------------------------------------------
  always_comb begin
    int          idx;
    int          gsel;
    logic [14:0] w;
    logic        hit;

    idx              = 0;
    gsel             = 0;
    w                = '0;
    hit              = 1'b0;
    cand             = '0;
    grant_found      = 1'b0;
    grant_idx        = '0;
    unused_addr_bits = 1'b0;

    for (int i = 0; i < NUM_REQ; i++) begin
      w   = req_addr[i*18+3 +: 15];
      hit = (hz_v[0] && hz_w[0] == w) || (hz_v[1] && hz_w[1] == w);
      // Writes are never held back: the bank forwards between its own stages.
      cand[i] = req_valid[i] && (req_we[i] || !hit);
      unused_addr_bits = unused_addr_bits ^ (^req_addr[i*18 +: 3]);
    end

    // Search order last_grant+1, last_grant+2, ... wrapping modulo NUM_REQ.
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_found && cand[idx]) begin
        grant_found = 1'b1;
        grant_idx   = IW'(idx);
      end
    end

    gsel      = int'(grant_idx);
    sel_word  = req_addr[gsel*18+3 +: 15];
    sel_data  = req_data[gsel*9 +: 9];
    sel_we    = req_we[gsel];
    sel_force = req_force[gsel];
  end

  // ---------------------------------------------------------------------------
  // FSM next state and grant output.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n     = state;
    start_clear = 1'b0;
    hs          = 1'b0;
    req_ready   = '0;

    unique case (state)
      ARB: begin
        // A clear request wins over every pending requester this cycle.
        if (clear_start) begin
          state_n     = CLEAR;
          start_clear = 1'b1;
        end else if (grant_found) begin
          hs                   = 1'b1;
          req_ready[grant_idx] = 1'b1;
        end
      end
      CLEAR: if (sweep_cnt == 15'h7FFF) state_n = DRAIN;
      DRAIN: if (drain_cnt) state_n = ARB;
      default: state_n = ARB;
    endcase
  end

  assign clear_busy = (state != ARB);
  assign rsp_data   = bank_rdata;

  // ---------------------------------------------------------------------------
  // State, sweep, hazard history, bank request and response pipeline.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of the others regardless of order.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB;
      sweep_cnt  <= '0;
      drain_cnt  <= 1'b0;
      clr_val    <= '0;
      last_grant <= IW'(NUM_REQ - 1);   // requester 0 searched first
      hz_v       <= '0;
      hz_w       <= '0;
      rd_v       <= 1'b0;
      rd_id      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      clear_done <= 1'b0;
      bank_req   <= '0;
    end else begin
      state      <= state_n;
      drain_cnt  <= (state == DRAIN) && !drain_cnt;
      clear_done <= (state == DRAIN) && drain_cnt;

      if (start_clear) begin
        clr_val   <= clear_value;
        sweep_cnt <= '0;
      end else if (state == CLEAR) begin
        sweep_cnt <= sweep_cnt + 15'd1;
      end

      hz_v    <= {hz_v[0], hs && sel_we};
      hz_w[1] <= hz_w[0];
      hz_w[0] <= sel_word;

      rd_v      <= hs && !sel_we;
      rd_id     <= grant_idx;
      rsp_valid <= rd_v;
      rsp_id    <= rd_id;

      bank_req.en         <= 1'b0;
      bank_req.forcewrite <= 1'b0;
      if (hs) begin
        last_grant          <= grant_idx;
        bank_req.addr       <= {sel_word, BANK_ID};
        bank_req.data       <= sel_data;
        bank_req.en         <= sel_we;
        bank_req.forcewrite <= sel_we & sel_force;
      end else if (state == CLEAR) begin
        bank_req.addr       <= {sweep_cnt, BANK_ID};
        bank_req.data       <= clr_val;
        bank_req.en         <= 1'b1;
        bank_req.forcewrite <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fb_bank_sched.sv
// -----------------------------------------------------------------------------
// tb_fb_bank_sched : self-checking bench for fb_bank_sched.
// A behavioural mem_bank (two write stages, registered read) sits behind the
// scheduler. The reference model works from cycle numbers: it keeps the last
// granted requester, a list of recent write handshakes, a word-level image of
// the bank and a queue of expected read responses.
// -----------------------------------------------------------------------------
module tb_fb_bank_sched;
  import fb_bank_pkg::*;

  localparam int         N       = 4;
  localparam int         WORDS   = 32768;
  localparam int         CLR_LEN = 32771;  // clear_start to clear_done
  localparam logic [2:0] BANK    = 3'd5;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid, req_ready, req_we, req_force;
  logic [N*18-1:0]   req_addr;
  logic [N*9-1:0]    req_data;
  logic              clear_start;
  logic [8:0]        clear_value;
  logic              clear_busy, clear_done;
  write_req_pkt      bank_req;
  logic [8:0]        bank_rdata;
  logic              rsp_valid;
  logic [1:0]        rsp_id;
  logic [8:0]        rsp_data;

  fb_bank_sched #(.NUM_REQ(N), .BANK_ID(BANK)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_force(req_force), .req_addr(req_addr), .req_data(req_data),
    .clear_start(clear_start), .clear_value(clear_value),
    .clear_busy(clear_busy), .clear_done(clear_done),
    .bank_req(bank_req), .bank_rdata(bank_rdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural mem_bank ----------------
  logic [8:0]   mem [WORDS];
  write_req_pkt w1, w2;
  always @(posedge clk) begin
    bank_rdata <= mem[bank_req.addr[17:3]];
    w1 <= bank_req;
    w2 <= w1;
    if (w2.en === 1'b1) mem[w2.addr[17:3]] <= w2.data;
  end

  // ---------------- reference model state ----------------
  typedef struct { int cyc; logic [14:0] word; } wr_t;
  typedef struct { int id; logic [8:0] data; int due; } rd_t;
  typedef struct {
    bit          en, fw, care;
    logic [17:0] addr;
    logic [8:0]  data;
  } breq_t;

  logic [8:0] exp_mem [WORDS];
  wr_t        hq[$];
  rd_t        rq[$];
  breq_t      m_prev;
  int         m_last, m_S, cyc, n_done;
  bit         m_active;
  logic [8:0] m_val;
  int         checks = 0, failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [14:0] req_word(input int i);
    return req_addr[i*18+3 +: 15];
  endfunction

  function automatic bit blocked(input logic [14:0] w);
    foreach (hq[j]) if (hq[j].cyc >= cyc - 2 && hq[j].word == w) return 1'b1;
    return 1'b0;
  endfunction

  // Evaluate one cycle at the falling edge: compare outputs with the model,
  // then advance the model as if the next rising edge had happened.
  task automatic cyc_eval();
    logic [N-1:0] exp_ready;
    int           g, i, idx;
    bit           in_window, start_acc, busy_exp, done_exp;
    logic [14:0]  w;
    rd_t          r;
    wr_t          h;

    @(negedge clk);
    check("bank_en", 32'(bank_req.en), 32'(m_prev.en));
    check("bank_fw", 32'(bank_req.forcewrite), 32'(m_prev.fw));
    if (m_prev.care) check("bank_addr", 32'(bank_req.addr), 32'(m_prev.addr));
    if (m_prev.en)   check("bank_data", 32'(bank_req.data), 32'(m_prev.data));

    if (rq.size() > 0 && rq[0].due == cyc) begin
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsp_id",    32'(rsp_id),    32'(rq[0].id));
      check("rsp_data",  32'(rsp_data),  32'(rq[0].data));
      void'(rq.pop_front());
    end else begin
      check("rsp_valid", 32'(rsp_valid), 32'd0);
    end

    busy_exp = m_active && cyc >= m_S + 1 && cyc <= m_S + CLR_LEN - 1;
    done_exp = m_active && cyc == m_S + CLR_LEN;
    check("clear_busy", 32'(clear_busy), 32'(busy_exp));
    check("clear_done", 32'(clear_done), 32'(done_exp));
    if (clear_done === 1'b1) n_done++;
    if (done_exp) begin
      for (int a = 0; a < WORDS; a++) exp_mem[a] = m_val;
      m_active = 1'b0;
    end

    in_window = m_active && cyc <= m_S + CLR_LEN - 1;
    start_acc = (clear_start === 1'b1) && !in_window;

    while (hq.size() > 0 && hq[0].cyc < cyc - 2) void'(hq.pop_front());

    exp_ready = '0;
    g = -1;
    if (!in_window && !start_acc) begin
      for (int k = 1; k <= N; k++) begin
        i = (m_last + k) % N;
        if (g < 0 && req_valid[i] && !(!req_we[i] && blocked(req_word(i)))) g = i;
      end
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_ready));

    if (start_acc) begin
      m_active = 1'b1;
      m_S      = cyc;
      m_val    = clear_value;
    end

    m_prev = '{default: 0};
    if (g >= 0) begin
      w           = req_word(g);
      m_last      = g;
      m_prev.care = 1'b1;
      m_prev.addr = {w, BANK};
      if (req_we[g]) begin
        exp_mem[w]  = req_data[g*9 +: 9];
        h.cyc       = cyc;
        h.word      = w;
        hq.push_back(h);
        m_prev.en   = 1'b1;
        m_prev.fw   = req_force[g];
        m_prev.data = req_data[g*9 +: 9];
      end else begin
        r.id   = g;
        r.data = exp_mem[w];
        r.due  = cyc + 2;
        rq.push_back(r);
      end
    end else if (m_active && cyc + 1 >= m_S + 2 && cyc + 1 <= m_S + WORDS + 1) begin
      idx         = cyc + 1 - m_S - 2;
      m_prev.en   = 1'b1;
      m_prev.fw   = 1'b1;
      m_prev.care = 1'b1;
      m_prev.addr = {15'(idx), BANK};
      m_prev.data = m_val;
    end
    cyc++;
  endtask

  task automatic cyc_next();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    cyc_eval();
    cyc_next();
  endtask

  task automatic set_req(input int i, input bit v, input bit we, input bit f,
                         input logic [14:0] word, input logic [8:0] d);
    req_valid[i]         = v;
    req_we[i]            = we;
    req_force[i]         = f;
    req_addr[i*18 +: 18] = {word, 3'($urandom)};
    req_data[i*9 +: 9]   = d;
  endtask

  task automatic idle_inputs();
    req_valid   = '0;
    req_we      = '0;
    req_force   = '0;
    clear_start = 1'b0;
  endtask

  task automatic rand_req(input bit all_valid);
    for (int i = 0; i < N; i++)
      set_req(i, all_valid || ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
              15'(15'h40 + $urandom_range(0, 7)), 9'($urandom));
  endtask

  // Reset held for one rising edge. A clear aborted here keeps the sweep
  // words already presented to the bank, since the bank itself is not reset.
  task automatic do_reset();
    int last_idx;
    rst = 1'b1;
    @(negedge clk);
    if (m_active) begin
      last_idx = cyc - m_S - 2;
      for (int a = 0; a <= last_idx && a < WORDS; a++) exp_mem[a] = m_val;
    end
    @(posedge clk);
    #1;
    rst      = 1'b0;
    cyc++;
    m_last   = N - 1;
    m_active = 1'b0;
    hq.delete();
    rq.delete();
    m_prev      = '{default: 0};
    m_prev.care = 1'b1;
  endtask

  task automatic check_reset_outputs();
    cyc_eval();
    check("rst_bank_req",  32'(bank_req),   32'd0);
    check("rst_req_ready", 32'(req_ready),  32'd0);
    check("rst_busy",      32'(clear_busy), 32'd0);
    check("rst_done",      32'(clear_done), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid),  32'd0);
    check("rst_rsp_id",    32'(rsp_id),     32'd0);
    cyc_next();
  endtask

  initial begin
    int t_words [12];
    req_addr    = '0;
    req_data    = '0;
    clear_value = '0;
    idle_inputs();
    for (int a = 0; a < WORDS; a++) begin
      mem[a]     = 9'd0;
      exp_mem[a] = 9'd0;
    end
    cyc      = 0;
    n_done   = 0;
    m_active = 1'b0;
    m_S      = 0;
    m_val    = '0;

    // ---- reset state ----
    do_reset();
    check_reset_outputs();

    // ---- all requesters writing continuously: grants 0,1,2,3,0,... ----
    for (int j = 0; j < 12; j++) begin
      for (int i = 0; i < N; i++)
        set_req(i, 1'b1, 1'b1, 1'($urandom), 15'(15'h100 + $urandom_range(0, 255)), 9'($urandom));
      cyc_eval();
      check("rr_order", 32'(req_ready), 32'(1 << (j % N)));
      cyc_next();
    end
    idle_inputs();
    repeat (3) step();

    // ---- read of a word written one cycle earlier waits two cycles ----
    set_req(0, 1'b1, 1'b1, 1'b0, 15'h10, 9'd5);
    cyc_eval(); check("hz_wr_grant", 32'(req_ready), 32'b0001); cyc_next();
    idle_inputs();
    set_req(1, 1'b1, 1'b0, 1'b0, 15'h10, 9'd0);
    cyc_eval(); check("hz_blk_t1", 32'(req_ready), 32'b0000); cyc_next();
    cyc_eval(); check("hz_blk_t2", 32'(req_ready), 32'b0000); cyc_next();
    cyc_eval(); check("hz_grant_t3", 32'(req_ready), 32'b0010); cyc_next();
    idle_inputs();
    step();
    cyc_eval();
    check("hz_rsp_valid", 32'(rsp_valid), 32'd1);
    check("hz_rsp_id",    32'(rsp_id),    32'd1);
    check("hz_rsp_data",  32'(rsp_data),  32'd5);
    cyc_next();
    repeat (2) step();

    // ---- read of a different word is not held back ----
    set_req(0, 1'b1, 1'b1, 1'b1, 15'h10, 9'h0AB);
    step();
    idle_inputs();
    set_req(2, 1'b1, 1'b0, 1'b0, 15'h20, 9'd0);
    cyc_eval(); check("nohz_grant", 32'(req_ready), 32'b0100); cyc_next();
    idle_inputs();
    step();
    cyc_eval();
    check("nohz_rsp_valid", 32'(rsp_valid), 32'd1);
    check("nohz_rsp_id",    32'(rsp_id),    32'd2);
    check("nohz_rsp_data",  32'(rsp_data),  32'd0);
    cyc_next();
    repeat (2) step();

    // ---- randomized traffic on a small word set ----
    for (int j = 0; j < 2000; j++) begin
      rand_req(1'b0);
      step();
    end

    // ---- full clear with every requester valid; a second start is ignored ----
    n_done = 0;
    rand_req(1'b1);
    clear_start = 1'b1;
    clear_value = 9'h1FF;
    step();
    for (int j = 1; j < CLR_LEN; j++) begin
      rand_req(1'b1);
      clear_start = (j == 100);
      clear_value = (j == 100) ? 9'h0AA : 9'h000;
      step();
    end
    idle_inputs();
    for (int a = 0; a < WORDS; a++) begin
      req_valid = '0;
      set_req(0, 1'b1, 1'b0, 1'b0, 15'(a), 9'd0);
      cyc_eval();
      if (a == 0) check("clr_done_pulse", 32'(clear_done), 32'd1);
      cyc_next();
    end
    idle_inputs();
    repeat (3) step();
    check("clr_done_count", 32'(n_done), 32'd1);

    // ---- reset while the sweep is at index 1000 ----
    n_done = 0;
    clear_start = 1'b1;
    clear_value = 9'h055;
    step();
    clear_start = 1'b0;
    for (int j = 1; j <= 1000; j++) step();
    do_reset();
    check_reset_outputs();
    repeat (10) step();
    t_words = '{0, 998, 999, 1000, 1001, 1500, 32767, 500, 2000, 999, 1000, 12345};
    foreach (t_words[k]) begin
      req_valid = '0;
      set_req(0, 1'b1, 1'b0, 1'b0, 15'(t_words[k]), 9'd0);
      step();
    end
    idle_inputs();
    repeat (3) step();
    check("abort_no_done", 32'(n_done), 32'd0);
    check("abort_old_1000", 32'(exp_mem[1000]), 32'h1FF);
    check("abort_new_999",  32'(exp_mem[999]),  32'h055);
    check("rsp_queue_empty", 32'(rq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
